// File: rtl/tp_pkg.sv
// Shared types for the note-sequence classifier datapath:
// note and tipo codes, classifier states and the note FIFO word.
package tp_pkg;

  typedef enum logic [2:0] {
    nota_x   = 3'd0,
    nota_do  = 3'd1,
    nota_re  = 3'd2,
    nota_mi  = 3'd3,
    nota_fa  = 3'd4,
    nota_sol = 3'd5,
    nota_la  = 3'd6,
    nota_si  = 3'd7
  } nota_t;

  typedef enum logic [1:0] {
    tipo_nulo = 2'd0,
    tipo_adj  = 2'd1,
    tipo_comp = 2'd2,
    tipo_adv  = 2'd3
  } tipo_t;

  typedef enum logic [4:0] {
    st_ini   = 5'b00001,
    st_nota  = 5'b00010,
    st_tom   = 5'b00100,
    st_class = 5'b01000,
    st_fim   = 5'b10000
  } cls_state_t;

  typedef struct packed {
    logic       tom;
    logic [2:0] nota;
  } note_entry_t;

  typedef enum logic {
    D_IDLE = 1'b0,
    D_GAP  = 1'b1
  } drain_t;

endpackage

// File: rtl/note_debounce.sv
// Board input synchroniser and button debouncer with rise pulse.
// NOTE_DEBOUNCE_EN enables the counter; otherwise the sync level is used.
module note_debounce
  import tp_pkg::*;
#(
  parameter int DB_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_raw,
  input  logic       sw_tom,
  input  logic [2:0] sw_nota,
  output logic       rise,
  output logic       tom_s,
  output logic [2:0] nota_s
);

  logic       btn_m;
  logic       btn_s;
  logic       tom_m;
  logic [2:0] nota_m;
  logic       level;
  logic       level_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      btn_m   <= 1'b0;
      btn_s   <= 1'b0;
      tom_m   <= 1'b0;
      tom_s   <= 1'b0;
      nota_m  <= '0;
      nota_s  <= '0;
      level_q <= 1'b0;
    end else begin
      btn_m   <= btn_raw;
      btn_s   <= btn_m;
      tom_m   <= sw_tom;
      tom_s   <= tom_m;
      nota_m  <= sw_nota;
      nota_s  <= nota_m;
      level_q <= level;
    end
  end

`ifdef NOTE_DEBOUNCE_EN
  localparam int CW = $clog2(DB_CYCLES + 1);

  logic [CW-1:0] cnt;
  logic          db_lvl;

  // Any cycle agreeing with the accepted level restarts the run.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      db_lvl <= 1'b0;
    end else if (btn_s == db_lvl) begin
      cnt <= '0;
    end else if (cnt == CW'(DB_CYCLES - 1)) begin
      db_lvl <= btn_s;
      cnt    <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign level = db_lvl;
`else
  logic unused_db;

  assign unused_db = DB_CYCLES > 0;
  assign level     = btn_s;
`endif

  assign rise = level & ~level_q;

endmodule

// File: rtl/note_entry_sequencer.sv
// Captures debounced OK presses into a FIFO and replays them as spaced
// ok strobes. NOTE_DEBOUNCE_EN selects the debounce counter.
module note_entry_sequencer
  import tp_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int DB_CYCLES  = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     btn_raw,
  input  logic                     sw_tom,
  input  logic [2:0]               sw_nota,
  input  logic                     fim_in,
  output logic                     ok,
  output logic                     tom,
  output logic [2:0]               nota,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  note_entry_t mem [DEPTH];
  note_entry_t head;

  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          rise;
  logic          tom_s;
  logic [2:0]    nota_s;
  drain_t        state;
  drain_t        state_n;
  logic [GW-1:0] gcnt;
  logic [GW-1:0] gcnt_n;
  logic          ok_n;
  logic          pop;
  logic          push;
  logic          full;
  logic          empty;
  logic          wr_en;

  note_debounce #(
    .DB_CYCLES(DB_CYCLES)
  ) u_db (
    .clk    (clk),
    .reset  (reset),
    .btn_raw(btn_raw),
    .sw_tom (sw_tom),
    .sw_nota(sw_nota),
    .rise   (rise),
    .tom_s  (tom_s),
    .nota_s (nota_s)
  );

  assign count = wr_ptr - rd_ptr;
  assign full  = count == (AW + 1)'(DEPTH);
  assign empty = count == '0;
  assign head  = mem[rd_ptr[AW-1:0]];
  assign push  = rise & ~fim_in;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign wr_en = push & (~full | pop);

  always_comb begin
    state_n = state;
    gcnt_n  = gcnt;
    ok_n    = 1'b0;
    pop     = 1'b0;
    unique case (state)
      D_IDLE: begin
        if (!empty) begin
          ok_n    = 1'b1;
          pop     = 1'b1;
          gcnt_n  = GW'(GAP_CYCLES);
          state_n = D_GAP;
        end
      end
      D_GAP: begin
        if (gcnt == '0) begin
          state_n = D_IDLE;
        end else begin
          gcnt_n = gcnt - 1'b1;
        end
      end
      default: state_n = D_IDLE;
    endcase
    if (fim_in) begin
      state_n = D_IDLE;
      gcnt_n  = '0;
      ok_n    = 1'b0;
      pop     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= D_IDLE;
      gcnt     <= '0;
      ok       <= 1'b0;
      tom      <= 1'b0;
      nota     <= '0;
      overflow <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      state <= state_n;
      gcnt  <= gcnt_n;
      ok    <= ok_n;
      if (pop) begin
        tom  <= head.tom;
        nota <= head.nota;
      end
      if (push && full && !pop) begin
        overflow <= 1'b1;
      end
      if (fim_in) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_en) wr_ptr <= wr_ptr + 1'b1;
        if (pop)   rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr[AW-1:0]] <= '{tom: tom_s, nota: nota_s};
    end
  end

endmodule

// File: tb/tb_note_entry_sequencer.sv
// Bench for note_entry_sequencer: timeline stimulus with a press-level
// reference; a second instance with a long gap exercises overflow.
module tb_note_entry_sequencer;

  localparam int DEPTH = 8;
  localparam int DB    = 4;
  localparam int GAP   = 1;
  localparam int GAP_B = 200;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef NOTE_DEBOUNCE_EN
  localparam int DBE   = DB;
`else
  localparam int DBE   = 0;
`endif
  // Edges from the first raw high sample to the ok strobe.
  localparam int LAT   = 2 + DBE + 1 + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          btn_raw;
  logic          sw_tom;
  logic [2:0]    sw_nota;
  logic          fim_in;
  logic          ok_a, tom_a, ovf_a;
  logic [2:0]    nota_a;
  logic [CW-1:0] count_a;
  logic          ok_b, tom_b, ovf_b;
  logic [2:0]    nota_b;
  logic [CW-1:0] count_b;

  int n_chk = 0;
  int n_fail = 0;

  bit         bq[$];
  bit         tq[$];
  logic [2:0] nq[$];
  bit         fq[$];
  bit         eo[$];
  bit         ec[$];
  logic [3:0] ee[$];
  int         pidx[$];
  logic [3:0] pe[$];
  int         fidx[$];
  logic [3:0] hold_a;

  always #5 clk = ~clk;

  note_entry_sequencer #(
    .DEPTH(DEPTH), .DB_CYCLES(DB), .GAP_CYCLES(GAP)
  ) dut_a (
    .clk(clk), .reset(reset), .btn_raw(btn_raw),
    .sw_tom(sw_tom), .sw_nota(sw_nota), .fim_in(fim_in),
    .ok(ok_a), .tom(tom_a), .nota(nota_a),
    .count(count_a), .overflow(ovf_a)
  );

  note_entry_sequencer #(
    .DEPTH(DEPTH), .DB_CYCLES(DB), .GAP_CYCLES(GAP_B)
  ) dut_b (
    .clk(clk), .reset(reset), .btn_raw(btn_raw),
    .sw_tom(sw_tom), .sw_nota(sw_nota), .fim_in(fim_in),
    .ok(ok_b), .tom(tom_b), .nota(nota_b),
    .count(count_b), .overflow(ovf_b)
  );

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; btn_raw = 1'b0; sw_tom = 1'b0;
    sw_nota = 3'b000; fim_in = 1'b0;
    step(2);
    reset = 1'b0;
    hold_a = 4'h0;
  endtask

  task automatic clear_tl();
    bq = {}; tq = {}; nq = {}; fq = {}; eo = {}; ec = {};
    ee = {}; pidx = {}; pe = {}; fidx = {};
  endtask

  task automatic add_idle(input int k);
    bit t;
    logic [2:0] n;
    t = (tq.size() > 0) ? tq[$] : 1'b0;
    n = (nq.size() > 0) ? nq[$] : 3'b000;
    repeat (k) begin
      bq.push_back(1'b0); tq.push_back(t); nq.push_back(n);
    end
  endtask

  // One press: entry appears at index p+LAT-1 unless flushed on push.
  task automatic add_press(input bit t, input logic [2:0] n,
                           input int hi, input int lo, input bit fl);
    int p;
    p = bq.size();
    repeat (hi) begin
      bq.push_back(1'b1); tq.push_back(t); nq.push_back(n);
    end
    repeat (lo) begin
      bq.push_back(1'b0); tq.push_back(t); nq.push_back(n);
    end
    if (fl) begin
      fidx.push_back(p + LAT - 2);
    end else begin
      pidx.push_back(p + LAT - 1);
      pe.push_back({t, n});
    end
  endtask

  task automatic add_glitch(input int w);
    bit t;
    logic [2:0] n;
    t = (tq.size() > 0) ? tq[$] : 1'b0;
    n = (nq.size() > 0) ? nq[$] : 3'b000;
    repeat (w) begin
      bq.push_back(1'b1); tq.push_back(t); nq.push_back(n);
    end
    add_idle(DBE + 3);
  endtask

  task automatic finalize(input int tail);
    add_idle(tail);
    foreach (bq[i]) begin
      fq.push_back(1'b0); eo.push_back(1'b0);
      ec.push_back(1'b0); ee.push_back(4'h0);
    end
    foreach (fidx[i]) fq[fidx[i]] = 1'b1;
    foreach (pidx[i]) begin
      eo[pidx[i]]     = 1'b1;
      ee[pidx[i]]     = pe[i];
      ec[pidx[i] - 1] = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; btn_raw = 1'b1; sw_tom = 1'b1;
    sw_nota = 3'b111; fim_in = 1'b0;
    step(3);
    n_chk++;
    if ({ok_a, tom_a, nota_a, ovf_a} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_out got %b exp 000000",
               {ok_a, tom_a, nota_a, ovf_a});
    end
    n_chk++;
    if (count_a !== '0 || count_b !== '0) begin
      n_fail++;
      $display("FAIL reset_count got %0d/%0d exp 0", count_a, count_b);
    end
    do_reset();
  endtask

  task automatic test_single();
    do_reset(); clear_tl();
    add_press(1'b0, 3'b110, 10, 10, 1'b0);
    finalize(LAT + 4);
    for (int i = 0; i < bq.size(); i++) begin
      btn_raw = bq[i]; sw_tom = tq[i]; sw_nota = nq[i]; fim_in = fq[i];
      step();
      if (eo[i]) hold_a = ee[i];
      n_chk++;
      if (ok_a !== eo[i]) begin
        n_fail++;
        $display("FAIL single_ok i=%0d got %b exp %b", i, ok_a, eo[i]);
      end
      n_chk++;
      if ({tom_a, nota_a} !== hold_a) begin
        n_fail++;
        $display("FAIL single_entry i=%0d got %h exp %h",
                 i, {tom_a, nota_a}, hold_a);
      end
      n_chk++;
      if (count_a !== CW'(ec[i])) begin
        n_fail++;
        $display("FAIL single_count i=%0d got %0d exp %0d",
                 i, count_a, ec[i]);
      end
    end
  endtask

  task automatic test_glitch();
    do_reset(); clear_tl();
`ifdef NOTE_DEBOUNCE_EN
    add_glitch(DB - 1);
`else
    add_press(1'b1, 3'b101, 1, 6, 1'b0);
`endif
    finalize(LAT + 6);
    for (int i = 0; i < bq.size(); i++) begin
      btn_raw = bq[i]; sw_tom = tq[i]; sw_nota = nq[i]; fim_in = fq[i];
      step();
      n_chk++;
      if (ok_a !== eo[i]) begin
        n_fail++;
        $display("FAIL glitch_ok i=%0d got %b exp %b", i, ok_a, eo[i]);
      end
      n_chk++;
      if (count_a !== CW'(ec[i])) begin
        n_fail++;
        $display("FAIL glitch_count i=%0d got %0d exp %0d",
                 i, count_a, ec[i]);
      end
    end
  endtask

  task automatic test_three();
    do_reset(); clear_tl();
    add_press(1'b1, 3'b111, DBE + 2, DBE + 2, 1'b0);
    add_press(1'b0, 3'b110, DBE + 2, DBE + 2, 1'b0);
    add_press(1'b1, 3'b001, DBE + 2, DBE + 2, 1'b0);
    finalize(LAT + 4);
    for (int i = 0; i < bq.size(); i++) begin
      btn_raw = bq[i]; sw_tom = tq[i]; sw_nota = nq[i]; fim_in = fq[i];
      step();
      if (eo[i]) hold_a = ee[i];
      n_chk++;
      if (ok_a !== eo[i]) begin
        n_fail++;
        $display("FAIL three_ok i=%0d got %b exp %b", i, ok_a, eo[i]);
      end
      n_chk++;
      if ({tom_a, nota_a} !== hold_a) begin
        n_fail++;
        $display("FAIL three_entry i=%0d got %h exp %h",
                 i, {tom_a, nota_a}, hold_a);
      end
    end
  endtask

  task automatic test_flush();
    do_reset(); clear_tl();
    add_press(1'b1, 3'b011, DBE + 2, DBE + 4, 1'b1);
    add_press(1'b0, 3'b100, DBE + 2, DBE + 2, 1'b0);
    finalize(LAT + 4);
    for (int i = 0; i < bq.size(); i++) begin
      btn_raw = bq[i]; sw_tom = tq[i]; sw_nota = nq[i]; fim_in = fq[i];
      step();
      if (eo[i]) hold_a = ee[i];
      n_chk++;
      if (ok_a !== eo[i]) begin
        n_fail++;
        $display("FAIL flush_ok i=%0d got %b exp %b", i, ok_a, eo[i]);
      end
      n_chk++;
      if ({tom_a, nota_a} !== hold_a) begin
        n_fail++;
        $display("FAIL flush_entry i=%0d got %h exp %h",
                 i, {tom_a, nota_a}, hold_a);
      end
      n_chk++;
      if (count_a !== CW'(ec[i])) begin
        n_fail++;
        $display("FAIL flush_count i=%0d got %0d exp %0d",
                 i, count_a, ec[i]);
      end
    end
    fim_in = 1'b0;
    n_chk++;
    if (ovf_a !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_ovf got %b exp 0", ovf_a);
    end
  endtask

  task automatic test_random();
    do_reset(); clear_tl();
    for (int k = 0; k < 12; k++) begin
      add_press(1'($urandom), 3'($urandom),
                DBE + 2 + int'($urandom_range(0, 3)),
                DBE + 3 + int'($urandom_range(0, 3)), 1'b0);
`ifdef NOTE_DEBOUNCE_EN
      if ($urandom_range(0, 1) == 1) add_glitch(int'($urandom_range(1, DB - 1)));
`endif
    end
    finalize(LAT + 4);
    for (int i = 0; i < bq.size(); i++) begin
      btn_raw = bq[i]; sw_tom = tq[i]; sw_nota = nq[i]; fim_in = fq[i];
      step();
      if (eo[i]) hold_a = ee[i];
      n_chk++;
      if (ok_a !== eo[i]) begin
        n_fail++;
        $display("FAIL rand_ok i=%0d got %b exp %b", i, ok_a, eo[i]);
      end
      n_chk++;
      if ({tom_a, nota_a} !== hold_a) begin
        n_fail++;
        $display("FAIL rand_entry i=%0d got %h exp %h",
                 i, {tom_a, nota_a}, hold_a);
      end
      n_chk++;
      if (count_a !== CW'(ec[i])) begin
        n_fail++;
        $display("FAIL rand_count i=%0d got %0d exp %0d",
                 i, count_a, ec[i]);
      end
    end
  endtask

  // Long-gap instance: first press drains at once, the next
  // DEPTH fill the FIFO and the last one is dropped.
  task automatic test_overflow();
    logic [3:0] ent [10];
    int seen, last, tmo;
    do_reset(); clear_tl();
    for (int k = 0; k < 10; k++) begin
      ent[k] = {1'($urandom), 3'($urandom_range(1, 7))};
      add_press(ent[k][3], ent[k][2:0], DBE + 2, DBE + 2, 1'b0);
    end
    finalize(LAT);
    for (int i = 0; i < bq.size(); i++) begin
      btn_raw = bq[i]; sw_tom = tq[i]; sw_nota = nq[i]; fim_in = fq[i];
      step();
    end
    btn_raw = 1'b0;
    n_chk++;
    if (count_b !== CW'(DEPTH)) begin
      n_fail++;
      $display("FAIL ovf_count got %0d exp %0d", count_b, DEPTH);
    end
    n_chk++;
    if (ovf_b !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_flag got %b exp 1", ovf_b);
    end
    seen = 0; last = 0; tmo = 0;
    while (seen < DEPTH && tmo < DEPTH * (GAP_B + 2) + 50) begin
      step(); tmo++;
      if (ok_b) begin
        n_chk++;
        if ({tom_b, nota_b} !== ent[seen + 1]) begin
          n_fail++;
          $display("FAIL ovf_order n=%0d got %h exp %h",
                   seen, {tom_b, nota_b}, ent[seen + 1]);
        end
        if (seen > 0) begin
          n_chk++;
          if (tmo - last != GAP_B + 2) begin
            n_fail++;
            $display("FAIL ovf_spacing got %0d exp %0d",
                     tmo - last, GAP_B + 2);
          end
        end
        last = tmo; seen++;
      end
    end
    n_chk++;
    if (seen != DEPTH) begin
      n_fail++;
      $display("FAIL ovf_drain got %0d pulses exp %0d", seen, DEPTH);
    end
    step(GAP_B + 5);
    n_chk++;
    if (count_b !== '0 || ovf_b !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_sticky got count %0d ovf %b exp 0/1",
               count_b, ovf_b);
    end
  endtask

  task automatic test_reset_gap();
    clear_tl();
    add_press(1'b1, 3'b101, DBE + 2, DBE + 2, 1'b0);
    for (int k = 0; k < 3; k++) begin
      add_press(1'($urandom), 3'($urandom), DBE + 2, DBE + 2, 1'b0);
    end
    finalize(LAT);
    for (int i = 0; i < bq.size(); i++) begin
      btn_raw = bq[i]; sw_tom = tq[i]; sw_nota = nq[i]; fim_in = fq[i];
      step();
    end
    n_chk++;
    if (count_b !== CW'(3) || {tom_b, nota_b} !== 4'hD) begin
      n_fail++;
      $display("FAIL gap_setup got count %0d entry %h exp 3/d",
               count_b, {tom_b, nota_b});
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_chk++;
    if ({ok_b, tom_b, nota_b, ovf_b} !== 6'b0 || count_b !== '0) begin
      n_fail++;
      $display("FAIL gap_reset got %b count %0d exp 000000/0",
               {ok_b, tom_b, nota_b, ovf_b}, count_b);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; btn_raw = 1'b0; sw_tom = 1'b0;
    sw_nota = 3'b000; fim_in = 1'b0; hold_a = 4'h0;
    test_reset();
    test_single();
    test_glitch();
    test_three();
    test_flush();
    test_random();
    test_overflow();
    test_reset_gap();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
